// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the multi-digit counter.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0] BCD_MIN = 4'd0;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: clear, parallel load with illegal-digit squash,
// and a single up or down step with 9<->0 rollover.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  output logic [3:0] q,
  output logic       is_max,
  output logic       is_min
);

  logic [3:0] q_inc;
  logic [3:0] q_dec;

  assign is_max = (q == BCD_MAX);
  assign is_min = (q == BCD_MIN);
  assign q_inc  = is_max ? BCD_MIN : q + 4'd1;
  assign q_dec  = is_min ? BCD_MAX : q - 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= is_bcd(ld_val) ? ld_val : BCD_MIN;
    end else if (step) begin
      q <= up ? q_inc : q_dec;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with carry/borrow, load and clear.
// Digit steps ripple through an AND chain of lower-digit max/min flags.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter bit          WRAP_DOWN = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    updown_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [BCD_W*DIGITS-1:0] load_value_i,
  output logic [BCD_W*DIGITS-1:0] bcd_o,
  output logic                    carry_o,
  output logic                    borrow_o,
  output logic                    load_err_o
);

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_min;
  logic [DIGITS-1:0] step;
  logic              count;
  logic              hold;
  logic              ld_bad;

  assign count    = enable_i & ~rst_i & ~clear_i & ~load_i;
  assign carry_o  = count & updown_i & (&is_max);
  assign borrow_o = count & ~updown_i & (&is_min);
  // Saturating mode freezes every digit at all-zero
  assign hold     = borrow_o & ~WRAP_DOWN;

  always_comb begin : step_chain
    logic run;
    step = '0;
    run  = count & ~hold;
    for (int k = 0; k < DIGITS; k++) begin
      step[k] = run;
      run     = run & (updown_i ? is_max[k] : is_min[k]);
    end
  end

  always_comb begin
    ld_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!is_bcd(load_value_i[BCD_W*k +: BCD_W])) ld_bad = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      load_err_o <= 1'b0;
    end else if (load_i && ld_bad) begin
      load_err_o <= 1'b1;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr    (clear_i),
      .ld     (load_i),
      .ld_val (load_value_i[BCD_W*g +: BCD_W]),
      .step   (step[g]),
      .up     (updown_i),
      .q      (bcd_o[BCD_W*g +: BCD_W]),
      .is_max (is_max[g]),
      .is_min (is_min[g])
    );
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: 2-digit saturating, 2-digit wrapping and
// 4-digit instances share stimulus and are checked against an integer model.
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic rst, en, ud, clr, ld;
  logic [31:0] lv;

  logic [7:0]  bcd_s, bcd_w;
  logic [15:0] bcd_4;
  logic [2:0]  cy, bw, le;
  logic [31:0] obs_bcd [3];

  int checks = 0;
  int errors = 0;

  int unsigned m_val [3];
  bit          m_err [3];
  int unsigned nd  [3] = '{2, 2, 4};
  int unsigned lim [3] = '{100, 100, 10000};
  bit          wr  [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  assign obs_bcd[0] = {24'd0, bcd_s};
  assign obs_bcd[1] = {24'd0, bcd_w};
  assign obs_bcd[2] = {16'd0, bcd_4};

  bcd_counter_n #(.DIGITS(2), .WRAP_DOWN(1'b0)) u_sat (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .updown_i(ud),
    .clear_i(clr), .load_i(ld), .load_value_i(lv[7:0]),
    .bcd_o(bcd_s), .carry_o(cy[0]), .borrow_o(bw[0]),
    .load_err_o(le[0]));

  bcd_counter_n #(.DIGITS(2), .WRAP_DOWN(1'b1)) u_wrap (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .updown_i(ud),
    .clear_i(clr), .load_i(ld), .load_value_i(lv[7:0]),
    .bcd_o(bcd_w), .carry_o(cy[1]), .borrow_o(bw[1]),
    .load_err_o(le[1]));

  bcd_counter_n #(.DIGITS(4), .WRAP_DOWN(1'b0)) u_four (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .updown_i(ud),
    .clear_i(clr), .load_i(ld), .load_value_i(lv[15:0]),
    .bcd_o(bcd_4), .carry_o(cy[2]), .borrow_o(bw[2]),
    .load_err_o(le[2]));

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit exp_cy(input int i);
    return !rst && !clr && !ld && en && ud && m_val[i] == lim[i] - 1;
  endfunction

  function automatic bit exp_bw(input int i);
    return !rst && !clr && !ld && en && !ud && m_val[i] == 0;
  endfunction

  task automatic drive(input logic r, input logic c, input logic l,
                       input logic [31:0] v, input logic e, input logic u);
    rst = r; clr = c; ld = l; lv = v; en = e; ud = u;
    #1;
  endtask

  task automatic tick();
    int unsigned nv [3];
    bit ne [3];
    for (int i = 0; i < 3; i++) begin
      nv[i] = m_val[i];
      ne[i] = m_err[i];
      if (rst || clr) begin
        nv[i] = 0;
        ne[i] = 1'b0;
      end else if (ld) begin
        int unsigned p;
        p = 1;
        nv[i] = 0;
        for (int k = 0; k < nd[i]; k++) begin
          int unsigned nib;
          nib = lv[4*k +: 4];
          if (nib > 9) begin
            nib = 0;
            ne[i] = 1'b1;
          end
          nv[i] += nib * p;
          p *= 10;
        end
      end else if (en) begin
        if (ud) nv[i] = (m_val[i] + 1) % lim[i];
        else if (m_val[i] == 0) nv[i] = wr[i] ? lim[i] - 1 : 0;
        else nv[i] = m_val[i] - 1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_val[i] = nv[i];
      m_err[i] = ne[i];
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 32'h0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cy[i] !== 1'b0 || bw[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags inst%0d: carry=%b borrow=%b expected 0 0", i, cy[i], bw[i]);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_bcd[i] !== 32'h0 || le[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: bcd=%h err=%b expected 0 0", i, obs_bcd[i], le[i]);
      end
    end
  endtask

  task automatic test_count_up();
    drive(0, 0, 0, 32'h0, 1, 1);
    for (int n = 0; n < 99; n++) begin
      checks++;
      if (cy[0] !== exp_cy(0) || cy[2] !== exp_cy(2)) begin
        errors++;
        $display("FAIL up_carry step%0d: carry=%b/%b expected %b/%b", n, cy[0], cy[2], exp_cy(0), exp_cy(2));
      end
      tick();
      checks++;
      if (obs_bcd[0] !== to_bcd(m_val[0]) || obs_bcd[2] !== to_bcd(m_val[2])) begin
        errors++;
        $display("FAIL up_value step%0d: bcd=%h/%h expected %h/%h", n, obs_bcd[0], obs_bcd[2], to_bcd(m_val[0]), to_bcd(m_val[2]));
      end
    end
    checks++;
    if (bcd_s !== 8'h99 || cy[0] !== 1'b1) begin
      errors++;
      $display("FAIL up_at_99: bcd=%h carry=%b expected 99 1", bcd_s, cy[0]);
    end
    tick();
    checks++;
    if (bcd_s !== 8'h00 || bcd_4 !== 16'h0100) begin
      errors++;
      $display("FAIL up_wrap: bcd=%h four=%h expected 00 0100", bcd_s, bcd_4);
    end
  endtask

  task automatic test_load_down();
    drive(0, 0, 1, 32'h10, 0, 0);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0);
    tick();
    checks++;
    if (bcd_s !== 8'h09 || bcd_w !== 8'h09 || bcd_4 !== 16'h0009) begin
      errors++;
      $display("FAIL down_borrow_digit: bcd=%h/%h/%h expected 09", bcd_s, bcd_w, bcd_4);
    end
    repeat (9) tick();
    checks++;
    if (bcd_s !== 8'h00 || bcd_w !== 8'h00) begin
      errors++;
      $display("FAIL down_to_zero: bcd=%h/%h expected 00", bcd_s, bcd_w);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bw[i] !== 1'b1 || bw[i] !== exp_bw(i) || cy[i] !== 1'b0) begin
        errors++;
        $display("FAIL borrow_flag inst%0d: borrow=%b carry=%b expected 1 0", i, bw[i], cy[i]);
      end
    end
    tick();
    checks++;
    if (bcd_s !== 8'h00 || bcd_w !== 8'h99 || bcd_4 !== 16'h0000) begin
      errors++;
      $display("FAIL underflow: sat=%h wrap=%h four=%h expected 00 99 0000", bcd_s, bcd_w, bcd_4);
    end
  endtask

  task automatic test_load_err();
    drive(0, 0, 1, 32'h3C, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_bcd[i] !== 32'h30 || le[i] !== 1'b1) begin
        errors++;
        $display("FAIL load_bad inst%0d: bcd=%h err=%b expected 30 1", i, obs_bcd[i], le[i]);
      end
    end
    drive(0, 0, 1, 32'h25, 0, 0);
    tick();
    checks++;
    if (bcd_s !== 8'h25 || le !== 3'b111) begin
      errors++;
      $display("FAIL err_sticky: bcd=%h err=%b expected 25 111", bcd_s, le);
    end
    drive(0, 1, 0, 32'h0, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_bcd[i] !== 32'h0 || le[i] !== 1'b0) begin
        errors++;
        $display("FAIL clear inst%0d: bcd=%h err=%b expected 0 0", i, obs_bcd[i], le[i]);
      end
    end
  endtask

  task automatic test_priority();
    drive(0, 0, 1, 32'h99, 0, 0);
    tick();
    drive(0, 0, 1, 32'h42, 1, 1);
    checks++;
    if (cy !== 3'b000 || bw !== 3'b000) begin
      errors++;
      $display("FAIL load_masks_carry: carry=%b borrow=%b expected 000 000", cy, bw);
    end
    tick();
    checks++;
    if (bcd_s !== 8'h42 || bcd_4 !== 16'h0042 || obs_bcd[1] !== to_bcd(m_val[1])) begin
      errors++;
      $display("FAIL load_over_count: bcd=%h/%h expected 42", bcd_s, bcd_4);
    end
    drive(0, 1, 1, 32'h55, 1, 0);
    checks++;
    if (bw !== 3'b000) begin
      errors++;
      $display("FAIL clear_masks_borrow: borrow=%b expected 000", bw);
    end
    tick();
    checks++;
    if (bcd_s !== 8'h00 || bcd_4 !== 16'h0000) begin
      errors++;
      $display("FAIL clear_over_load: bcd=%h/%h expected 00", bcd_s, bcd_4);
    end
  endtask

  task automatic test_digits4();
    drive(0, 0, 1, 32'h0999, 0, 0);
    tick();
    drive(0, 0, 0, 32'h0, 1, 1);
    checks++;
    if (cy[2] !== 1'b0 || cy[0] !== 1'b1) begin
      errors++;
      $display("FAIL four_carry: carry=%b expected inst2=0 inst0=1", cy);
    end
    tick();
    checks++;
    if (bcd_4 !== 16'h1000 || bcd_s !== 8'h00) begin
      errors++;
      $display("FAIL four_ripple: bcd=%h sat=%h expected 1000 00", bcd_4, bcd_s);
    end
    tick();
    drive(1, 0, 0, 32'h0, 1, 1);
    tick();
    checks++;
    if (bcd_4 !== 16'h0000 || bcd_s !== 8'h00) begin
      errors++;
      $display("FAIL four_reset: bcd=%h sat=%h expected 0000 00", bcd_4, bcd_s);
    end
  endtask

  task automatic test_random();
    logic u;
    u = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      logic [31:0] v;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) u = ~u;
      v = '0;
      for (int k = 0; k < 8; k++)
        v[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      drive(r < 2, r >= 2 && r < 5, r >= 5 && r < 12, v,
            $urandom_range(0, 3) != 0, u);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cy[i] !== exp_cy(i) || bw[i] !== exp_bw(i)) begin
          errors++;
          $display("FAIL rand_flags n%0d inst%0d: carry=%b borrow=%b expected %b %b", n, i, cy[i], bw[i], exp_cy(i), exp_bw(i));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_bcd[i] !== to_bcd(m_val[i]) || le[i] !== m_err[i]) begin
          errors++;
          $display("FAIL rand_state n%0d inst%0d: bcd=%h err=%b expected %h %b", n, i, obs_bcd[i], le[i], to_bcd(m_val[i]), m_err[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ld = 1'b0; lv = '0; en = 1'b0; ud = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_val[i] = 0;
      m_err[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_count_up();
    test_load_down();
    test_load_err();
    test_priority();
    test_digits4();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised multi-digit BCD up/down counter with ripple-carry and borrow outputs, synchronous parallel load, clear, and a selectable underflow mode (saturate or wrap). It is the successor to the team's single-digit BCD counter. It serves as the counting core for event tallies and display-driven counters. Digits are chained internally, so a single instance replaces a hand-cascaded chain of single-digit counters.

Parameters:
DIGITS, 4, number of BCD digits (1..8); counter range 0 .. 10^DIGITS-1
WRAP_DOWN, 0, 0 = counting down saturates at all-zero; 1 = all-zero wraps to all-nines

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
enable_i  in  1  count enable for the current cycle
updown_i  in  1  1 = count up, 0 = count down
clear_i  in  1  synchronous clear to zero
load_i  in  1  synchronous parallel load
load_value_i  in  4*DIGITS  load value; digit k in bits [4k+3:4k]
bcd_o  out  4*DIGITS  current count, registered; digit 0 is least significant
carry_o  out  1  combinational; up-count wrap at all-nines this cycle
borrow_o  out  1  combinational; down-count attempted at all-zero this cycle
load_err_o  out  1  registered, sticky; a load contained a digit value > 9

Behaviour:
- Reset (rst_i=1 at clock edge): bcd_o=0, load_err_o=0. carry_o and borrow_o read 0 while rst_i=1.
- Priority at each edge: rst_i > clear_i > load_i > enable_i. Lower-priority requests in the same cycle are ignored.
- clear_i: bcd_o <= 0 and load_err_o <= 0.
- load_i:
  - Each digit of load_value_i in 0..9 is loaded as given.
  - Any digit in 10..15 is loaded as 0 and sets load_err_o <= 1.
  - load_err_o stays set until clear_i or rst_i.
  - Load takes effect on the next edge; there is no count in the load cycle.
- Count up (enable_i=1, updown_i=1, no clear/load):
  - Digit 0 increments.
  - Digit k increments when digits 0..k-1 are all 9.
  - A digit at 9 that increments becomes 0.
  - All-nines goes to all-zero, and carry_o=1 in that cycle.
- Count down (enable_i=1, updown_i=0, no clear/load):
  - Digit k decrements when digits 0..k-1 are all 0.
  - A digit at 0 that decrements becomes 9.
  - At all-zero, borrow_o=1. The next value is all-zero if WRAP_DOWN=0, or all-nines if WRAP_DOWN=1.
- enable_i=0: hold the value. carry_o=0, borrow_o=0.
- carry_o and borrow_o:
  - Pure functions of the current state and this cycle's inputs; they are valid one cycle before the wrap edge.
  - Forced to 0 when rst_i, clear_i or load_i is asserted.
- Latency: one cycle from enable/load/clear to bcd_o.
- Every digit of bcd_o is always in 0..9. No illegal BCD value is reachable after reset.
- Reset asserted mid-count overrides everything on that edge.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MIN = 4'd0, BCD_MAX = 4'd9, BCD_W = 4
  - function is_bcd(digit)
- Sub-module bcd_digit, instantiated DIGITS times through a generate loop.
  - Inputs: clk_i, rst_i, clr, ld, ld_val, step, up.
  - Outputs: q, is_max, is_min.
  - Per-digit step enables come from AND chains of the lower digits' is_max/is_min flags, built in the top level.

Test Plan (DIGITS=2 unless noted):
- Reset, then enable up for 99 cycles -> bcd_o=8'h99, carry_o=0; on the 100th cycle carry_o=1, and the next edge gives bcd_o=8'h00.
- Load 8'h10, then count down 1 -> 8'h09 (digit 1 borrows); count down 9 more -> 8'h00; one more with WRAP_DOWN=0 -> borrow_o=1 and bcd_o stays 8'h00.
- WRAP_DOWN=1, bcd_o=8'h00, count down -> borrow_o=1, next bcd_o=8'h99.
- Load 8'h3C -> bcd_o=8'h30, load_err_o=1; then clear_i -> bcd_o=8'h00, load_err_o=0.
- bcd_o=8'h99, assert enable_i=1, updown_i=1 and load_i=1 (8'h42) together -> carry_o=0, bcd_o=8'h42; then clear_i and load_i together -> bcd_o=8'h00.
- DIGITS=4, bcd_o=16'h0999, count up -> 16'h1000; assert rst_i mid-count -> 16'h0000 on the next edge.
